// File: rtl/ace_pkg.sv
// Shared types for the ACE master-side completion logic.
package ace_pkg;

  // Drain state machine for the RACK/WACK tracker.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } ace_ack_state_e;

endpackage

// File: rtl/ace_ack_chan.sv
// One completion channel (read or write): address gating with a hold
// register, ack pulse generation, saturating outstanding counter and
// underflow detection.
//
// Handshake: a transfer happens in a cycle where valid and ready are both
// high. Once valid is forwarded to the bus it stays forwarded until ready
// arrives, even if the gating condition drops in the meantime.
module ace_ack_chan #(
  parameter int MaxTxns  = 8,
  parameter int CntWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                slv_valid_i,
  output logic                slv_ready_o,
  output logic                mst_valid_o,
  input  logic                mst_ready_i,
  input  logic                done_i,
  output logic                ack_o,
  output logic [CntWidth-1:0] cnt_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxns);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                hold_q, hold_d;
  logic                ack_q;
  logic                err_q, err_d;
  logic                allow;
  logic                addr_hs;
  logic                underflow;

  assign allow       = ((cnt_q < MaxCnt) & en_i) | hold_q;
  assign mst_valid_o = slv_valid_i & allow;
  assign slv_ready_o = mst_ready_i & allow;
  assign addr_hs     = mst_valid_o & mst_ready_i;

  // Keep the allow alive while a forwarded address waits for ready.
  assign hold_d = mst_valid_o & ~mst_ready_i;

  // A completion with nothing left to acknowledge (the ack already in
  // flight is about to consume the last count) is a protocol error.
  assign underflow = done_i & (cnt_q == CntWidth'(ack_q));
  assign err_d     = err_q | underflow;

  // Outstanding count: +1 per address handshake, -1 per ack pulse, floor 0.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({addr_hs, ack_q})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  // Channel state registers; ack is a one-cycle pulse after each completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      hold_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      ack_q  <= done_i;
      err_q  <= err_d;
    end
  end

  assign ack_o  = ack_q;
  assign cnt_o  = cnt_q;
  assign busy_o = hold_q | ack_q;
  assign err_o  = err_q;

endmodule

// File: rtl/ace_ack_tracker.sv
// Master-side ACE completion stage: issues RACK/WACK, limits outstanding
// reads/writes and offers a flush/drain handshake. state_o exposes the
// drain FSM for debug.
module ace_ack_tracker
  import ace_pkg::*;
#(
  parameter int MaxRdTxns = 8,
  parameter int MaxWrTxns = 8,
  parameter int CntWidth  = $clog2(((MaxRdTxns > MaxWrTxns) ? MaxRdTxns : MaxWrTxns) + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                slv_ar_valid_i,
  output logic                slv_ar_ready_o,
  output logic                mst_ar_valid_o,
  input  logic                mst_ar_ready_i,
  input  logic                slv_aw_valid_i,
  output logic                slv_aw_ready_o,
  output logic                mst_aw_valid_o,
  input  logic                mst_aw_ready_i,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  input  logic                b_valid_i,
  input  logic                b_ready_i,
  output logic                rack_o,
  output logic                wack_o,
  input  logic                flush_i,
  output logic                flush_done_o,
  output logic [CntWidth-1:0] rd_outstanding_o,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic                err_o,
  output ace_ack_state_e      state_o
);

  ace_ack_state_e state_q, state_d;
  logic           addr_en;
  logic           rd_busy, wr_busy;
  logic           rd_err, wr_err;
  logic           drained;

  // New addresses are only admitted while not flushing.
  assign addr_en = (state_q == IDLE);

  ace_ack_chan #(.MaxTxns(MaxRdTxns), .CntWidth(CntWidth)) u_rd_chan (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (addr_en),
    .slv_valid_i (slv_ar_valid_i),
    .slv_ready_o (slv_ar_ready_o),
    .mst_valid_o (mst_ar_valid_o),
    .mst_ready_i (mst_ar_ready_i),
    .done_i      (r_valid_i & r_ready_i & r_last_i),
    .ack_o       (rack_o),
    .cnt_o       (rd_outstanding_o),
    .busy_o      (rd_busy),
    .err_o       (rd_err)
  );

  ace_ack_chan #(.MaxTxns(MaxWrTxns), .CntWidth(CntWidth)) u_wr_chan (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (addr_en),
    .slv_valid_i (slv_aw_valid_i),
    .slv_ready_o (slv_aw_ready_o),
    .mst_valid_o (mst_aw_valid_o),
    .mst_ready_i (mst_aw_ready_i),
    .done_i      (b_valid_i & b_ready_i),
    .ack_o       (wack_o),
    .cnt_o       (wr_outstanding_o),
    .busy_o      (wr_busy),
    .err_o       (wr_err)
  );

  // Fully drained: nothing outstanding, no ack pulse and no held address.
  assign drained = (rd_outstanding_o == '0) & (wr_outstanding_o == '0) & ~rd_busy & ~wr_busy;

  // Drain FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush_i) state_d = DRAIN;
      DRAIN:   if (!flush_i) state_d = IDLE;
               else if (drained) state_d = DONE;
      DONE:    if (!flush_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign flush_done_o = (state_q == DONE);
  assign err_o        = rd_err | wr_err;
  assign state_o      = state_q;

endmodule

// File: tb/tb_ace_ack_tracker.sv
// Directed bench for ace_ack_tracker (MaxRdTxns=2, MaxWrTxns=4).
// Expected ack pulses go into exp_q as {is_wr, cycle}; a negedge monitor
// matches every rack/wack pulse against it.
module tb_ace_ack_tracker;
  import ace_pkg::*;

  localparam int W  = 33;
  localparam int CW = 3;

  logic clk;
  logic rst_i;
  logic slv_ar_valid_i, slv_ar_ready_o, mst_ar_valid_o, mst_ar_ready_i;
  logic slv_aw_valid_i, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready_i;
  logic r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i;
  logic rack_o, wack_o, flush_i, flush_done_o, err_o;
  logic [CW-1:0] rd_outstanding_o, wr_outstanding_o;
  ace_ack_state_e state_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];

  ace_ack_tracker #(.MaxRdTxns(2), .MaxWrTxns(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .slv_ar_valid_i   (slv_ar_valid_i),
    .slv_ar_ready_o   (slv_ar_ready_o),
    .mst_ar_valid_o   (mst_ar_valid_o),
    .mst_ar_ready_i   (mst_ar_ready_i),
    .slv_aw_valid_i   (slv_aw_valid_i),
    .slv_aw_ready_o   (slv_aw_ready_o),
    .mst_aw_valid_o   (mst_aw_valid_o),
    .mst_aw_ready_i   (mst_aw_ready_i),
    .r_valid_i        (r_valid_i),
    .r_ready_i        (r_ready_i),
    .r_last_i         (r_last_i),
    .b_valid_i        (b_valid_i),
    .b_ready_i        (b_ready_i),
    .rack_o           (rack_o),
    .wack_o           (wack_o),
    .flush_i          (flush_i),
    .flush_done_o     (flush_done_o),
    .rd_outstanding_o (rd_outstanding_o),
    .wr_outstanding_o (wr_outstanding_o),
    .err_o            (err_o),
    .state_o          (state_o)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_set(input logic v);
    slv_ar_valid_i = v;
    mst_ar_ready_i = v;
  endtask

  task automatic aw_set(input logic v);
    slv_aw_valid_i = v;
    mst_aw_ready_i = v;
  endtask

  task automatic r_beat(input logic last);
    r_valid_i = 1'b1;
    r_ready_i = 1'b1;
    r_last_i  = last;
    if (last) exp_q.push_back({1'b0, 32'(cyc + 1)});
  endtask

  task automatic r_off();
    r_valid_i = 1'b0;
    r_ready_i = 1'b0;
    r_last_i  = 1'b0;
  endtask

  task automatic b_beat();
    b_valid_i = 1'b1;
    b_ready_i = 1'b1;
    exp_q.push_back({1'b1, 32'(cyc + 1)});
  endtask

  task automatic b_off();
    b_valid_i = 1'b0;
    b_ready_i = 1'b0;
  endtask

  // Scoreboard comparison helper
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic match_ack(input logic is_wr);
    logic [W-1:0] key;
    int idx;
    key = {is_wr, 32'(cyc)};
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (idx < 0 && exp_q[i] == key) idx = i;
    end
    total++;
    if (idx < 0) begin
      bad++;
      $display("FAIL %s_pulse: got pulse at cycle %0d, required none", is_wr ? "wack" : "rack", cyc);
    end else begin
      exp_q.delete(idx);
    end
  endtask

  // Monitor: every ack pulse must match an expected entry
  always @(negedge clk) begin
    if (rack_o) match_ack(1'b0);
    if (wack_o) match_ack(1'b1);
  end

  // Stimulus
  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    ar_set(1'b0);
    aw_set(1'b0);
    r_off();
    b_off();
    repeat (3) tick();
    rst_i = 1'b0;
    #1;
    check("rst_rd_cnt", rd_outstanding_o, 0);
    check("rst_wr_cnt", wr_outstanding_o, 0);
    check("rst_rack", rack_o, 0);
    check("rst_wack", wack_o, 0);
    check("rst_flush_done", flush_done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_state", int'(state_o), int'(IDLE));

    // Single read: AR at cycle 0, R last at cycle 5, rack at 6, count 0 at 7
    ar_set(1'b1);
    #1;
    check("single_mst_ar_valid", mst_ar_valid_o, 1);
    check("single_slv_ar_ready", slv_ar_ready_o, 1);
    tick();
    ar_set(1'b0);
    #1;
    check("single_rd_cnt_1", rd_outstanding_o, 1);
    repeat (4) tick();
    r_beat(1'b1);
    tick();
    r_off();
    #1;
    check("single_rack", rack_o, 1);
    check("single_rd_cnt_still_1", rd_outstanding_o, 1);
    tick();
    check("single_rack_low", rack_o, 0);
    check("single_rd_cnt_0", rd_outstanding_o, 0);

    // Limit: two reads accepted, third stalled until a rack frees a slot
    ar_set(1'b1);
    tick();
    tick();
    #1;
    check("limit_slv_ar_ready", slv_ar_ready_o, 0);
    check("limit_mst_ar_valid", mst_ar_valid_o, 0);
    check("limit_rd_cnt", rd_outstanding_o, 2);
    tick();
    check("limit_still_stalled", slv_ar_ready_o, 0);
    r_beat(1'b1);
    tick();
    r_off();
    #1;
    check("limit_stall_during_rack", slv_ar_ready_o, 0);
    tick();
    check("limit_third_accepted", slv_ar_ready_o, 1);
    check("limit_rd_cnt_freed", rd_outstanding_o, 1);
    tick();
    ar_set(1'b0);
    #1;
    check("limit_rd_cnt_refilled", rd_outstanding_o, 2);

    // Burst: last=0,0,1 then last=1 gives two consecutive rack pulses
    r_beat(1'b0);
    tick();
    r_beat(1'b0);
    tick();
    r_beat(1'b1);
    tick();
    r_beat(1'b1);
    tick();
    r_off();
    #1;
    check("burst_rack_second", rack_o, 1);
    check("burst_rd_cnt_1", rd_outstanding_o, 1);
    tick();
    check("burst_rack_done", rack_o, 0);
    check("burst_rd_cnt_0", rd_outstanding_o, 0);
    check("burst_no_err", err_o, 0);

    // Simultaneous AW handshake and wack with three writes outstanding
    aw_set(1'b1);
    repeat (3) tick();
    aw_set(1'b0);
    #1;
    check("sim_wr_cnt_3", wr_outstanding_o, 3);
    b_beat();
    tick();
    b_off();
    aw_set(1'b1);
    #1;
    check("sim_wack", wack_o, 1);
    check("sim_aw_ready", slv_aw_ready_o, 1);
    tick();
    aw_set(1'b0);
    #1;
    check("sim_wr_cnt_held", wr_outstanding_o, 3);

    // Drain prep: down to one write, up to two reads
    b_beat();
    tick();
    b_beat();
    tick();
    b_off();
    ar_set(1'b1);
    tick();
    tick();
    ar_set(1'b0);
    #1;
    check("drain_prep_rd", rd_outstanding_o, 2);
    check("drain_prep_wr", wr_outstanding_o, 1);

    // Flush with a forwarded but unready AW: it must stay forwarded
    flush_i = 1'b1;
    slv_aw_valid_i = 1'b1;
    mst_aw_ready_i = 1'b0;
    #1;
    check("hold_aw_fwd", mst_aw_valid_o, 1);
    tick();
    check("drain_state", int'(state_o), int'(DRAIN));
    check("hold_aw_kept", mst_aw_valid_o, 1);
    ar_set(1'b1);
    #1;
    check("drain_ar_blocked", slv_ar_ready_o, 0);
    check("drain_ar_valid_blocked", mst_ar_valid_o, 0);
    mst_aw_ready_i = 1'b1;
    tick();
    ar_set(1'b0);
    aw_set(1'b0);
    #1;
    check("hold_wr_cnt", wr_outstanding_o, 2);
    check("hold_rd_cnt", rd_outstanding_o, 2);
    aw_set(1'b1);
    #1;
    check("drain_aw_blocked", slv_aw_ready_o, 0);
    check("drain_aw_valid_blocked", mst_aw_valid_o, 0);
    aw_set(1'b0);
    r_beat(1'b1);
    tick();
    r_beat(1'b1);
    tick();
    r_off();
    b_beat();
    tick();
    b_beat();
    tick();
    b_off();
    #1;
    check("drain_not_done_a", flush_done_o, 0);
    tick();
    check("drain_not_done_b", flush_done_o, 0);
    check("drain_rd_zero", rd_outstanding_o, 0);
    check("drain_wr_zero", wr_outstanding_o, 0);
    tick();
    check("drain_done", flush_done_o, 1);
    check("drain_state_done", int'(state_o), int'(DONE));
    flush_i = 1'b0;
    tick();
    check("drain_back_idle", int'(state_o), int'(IDLE));
    check("drain_done_low", flush_done_o, 0);
    ar_set(1'b1);
    #1;
    check("resume_ar_ready", slv_ar_ready_o, 1);
    tick();
    ar_set(1'b0);
    #1;
    check("resume_rd_cnt", rd_outstanding_o, 1);
    r_beat(1'b1);
    tick();
    r_off();
    tick();
    check("resume_rd_cnt_0", rd_outstanding_o, 0);

    // Flush while empty: one DRAIN cycle, then DONE
    flush_i = 1'b1;
    tick();
    check("empty_flush_drain", int'(state_o), int'(DRAIN));
    check("empty_flush_not_done", flush_done_o, 0);
    tick();
    check("empty_flush_done", flush_done_o, 1);
    flush_i = 1'b0;
    tick();
    check("empty_flush_idle", int'(state_o), int'(IDLE));

    // Underflow: B with no writes outstanding sets sticky err, wack still issued
    b_beat();
    #1;
    check("err_not_yet", err_o, 0);
    tick();
    b_off();
    #1;
    check("err_set", err_o, 1);
    check("err_wack", wack_o, 1);
    tick();
    check("err_wr_cnt_floor", wr_outstanding_o, 0);
    repeat (3) tick();
    check("err_sticky", err_o, 1);

    // Reset in the middle of a drain, with a completion in the same cycle
    ar_set(1'b1);
    tick();
    ar_set(1'b0);
    flush_i = 1'b1;
    tick();
    check("mid_drain_state", int'(state_o), int'(DRAIN));
    tick();
    check("mid_drain_rd_cnt", rd_outstanding_o, 1);
    rst_i = 1'b1;
    r_valid_i = 1'b1;
    r_ready_i = 1'b1;
    r_last_i = 1'b1;
    tick();
    r_off();
    rst_i = 1'b0;
    flush_i = 1'b0;
    #1;
    check("rst2_rd_cnt", rd_outstanding_o, 0);
    check("rst2_wr_cnt", wr_outstanding_o, 0);
    check("rst2_rack", rack_o, 0);
    check("rst2_wack", wack_o, 0);
    check("rst2_err", err_o, 0);
    check("rst2_flush_done", flush_done_o, 0);
    check("rst2_state", int'(state_o), int'(IDLE));
    tick();
    check("rst2_no_late_rack", rack_o, 0);

    // Final report
    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
